// File: rtl/core_defs_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, datapath mux selects, FSM states.
package core_defs_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC4    = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_ALU_WB  = 4'd5,
        S_ADDR    = 4'd6,
        S_MEM_RD  = 4'd7,
        S_LOAD_WB = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JAL     = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface multicycle_control_if;

    logic [6:0] opcode;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       trap;

    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, alusrcb, pcsource, aluop, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, alusrcb, pcsource, aluop, trap
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory state; flags the MEM_TIMEOUT-th stall.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // Held at zero outside memory states, so every entry starts from a clean count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!active || mem_ready) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = active && !mem_ready && (count >= LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I subset core; drives all datapath enables and aluop.
module multicycle_control
    import core_defs_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    state_t state;
    state_t next;
    logic   is_store;
    logic   mem_active;
    logic   timeout;

    assign mem_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (mem_active),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    // Load/store choice is latched in DECODE so ADDR never looks at opcode again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            is_store <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                is_store <= (bus.opcode == OP_STORE);
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:    next = S_FETCH;
            S_FETCH:   if (bus.mem_ready) next = S_DECODE;
                       else if (timeout)  next = S_TRAP;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:              next = S_EXEC_R;
                    OP_I:              next = S_EXEC_I;
                    OP_LOAD, OP_STORE: next = S_ADDR;
                    OP_BRANCH:         next = S_BRANCH;
                    OP_JAL:            next = S_JAL;
                    default:           next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: next = S_ALU_WB;
            S_ALU_WB:  next = S_FETCH;
            S_ADDR:    next = is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (bus.mem_ready) next = S_LOAD_WB;
                       else if (timeout)  next = S_TRAP;
            S_LOAD_WB: next = S_FETCH;
            S_MEM_WR:  if (bus.mem_ready) next = S_FETCH;
                       else if (timeout)  next = S_TRAP;
            S_BRANCH, S_JAL: next = S_FETCH;
            S_TRAP:    next = S_TRAP;
            default:   next = S_TRAP;
        endcase
    end

    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memtoreg    = MTR_ALUOUT;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = SRCB_RS2;
        bus.pcsource    = PCSRC_ALU;
        bus.aluop       = ALUOP_ADD;
        bus.trap        = 1'b0;
        case (state)
            S_FETCH: begin
                bus.memread  = 1'b1;
                bus.irwrite  = 1'b1;
                bus.alusrcb  = SRCB_FOUR;
                // PC advances only once the fetch actually completes.
                bus.pcwrite  = bus.mem_ready;
            end
            S_DECODE: bus.alusrcb = SRCB_IMM;
            S_EXEC_R: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNC;
            end
            S_EXEC_I: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
                bus.aluop   = ALUOP_FUNC;
            end
            S_ALU_WB: bus.regwrite = 1'b1;
            S_ADDR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_LOAD_WB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = MTR_MDR;
            end
            S_MEM_WR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca     = 1'b1;
                bus.aluop       = ALUOP_BR;
                bus.pcwritecond = 1'b1;
                bus.pcsource    = PCSRC_ALUOUT;
            end
            S_JAL: begin
                bus.pcwrite  = 1'b1;
                bus.pcsource = PCSRC_JUMP;
                bus.regwrite = 1'b1;
                bus.memtoreg = MTR_PC4;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: stimulus queues the expected control word per cycle, a monitor compares at negedge.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       trap;
    } ctl_t;

    typedef struct {
        int unsigned dut;
        ctl_t        exp;
        string       name;
    } exp_t;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    function automatic ctl_t mk(input logic pw, input logic pwc, input logic iord,
                                input logic mrd, input logic mwr, input logic irw,
                                input logic [1:0] mtr, input logic rw, input logic asa,
                                input logic [1:0] asb, input logic [1:0] pcs,
                                input logic [1:0] aop, input logic tr);
        mk = {pw, pwc, iord, mrd, mwr, irw, mtr, rw, asa, asb, pcs, aop, tr};
    endfunction

    //                            pw pwc io mr mw ir mtr    rw as  asb    pcs    aop    tr
    localparam ctl_t C_ZERO    = mk(N, N, N, N, N, N, 2'b00, N, N, 2'b00, 2'b00, 2'b00, N);
    localparam ctl_t C_FETCH_S = mk(N, N, N, Y, N, Y, 2'b00, N, N, 2'b01, 2'b00, 2'b00, N);
    localparam ctl_t C_FETCH_R = mk(Y, N, N, Y, N, Y, 2'b00, N, N, 2'b01, 2'b00, 2'b00, N);
    localparam ctl_t C_DECODE  = mk(N, N, N, N, N, N, 2'b00, N, N, 2'b10, 2'b00, 2'b00, N);
    localparam ctl_t C_EXEC_R  = mk(N, N, N, N, N, N, 2'b00, N, Y, 2'b00, 2'b00, 2'b10, N);
    localparam ctl_t C_EXEC_I  = mk(N, N, N, N, N, N, 2'b00, N, Y, 2'b10, 2'b00, 2'b10, N);
    localparam ctl_t C_ALU_WB  = mk(N, N, N, N, N, N, 2'b00, Y, N, 2'b00, 2'b00, 2'b00, N);
    localparam ctl_t C_ADDR    = mk(N, N, N, N, N, N, 2'b00, N, Y, 2'b10, 2'b00, 2'b00, N);
    localparam ctl_t C_MEM_RD  = mk(N, N, Y, Y, N, N, 2'b00, N, N, 2'b00, 2'b00, 2'b00, N);
    localparam ctl_t C_LOAD_WB = mk(N, N, N, N, N, N, 2'b01, Y, N, 2'b00, 2'b00, 2'b00, N);
    localparam ctl_t C_MEM_WR  = mk(N, N, Y, N, Y, N, 2'b00, N, N, 2'b00, 2'b00, 2'b00, N);
    localparam ctl_t C_BRANCH  = mk(N, Y, N, N, N, N, 2'b00, N, Y, 2'b00, 2'b01, 2'b01, N);
    localparam ctl_t C_JAL     = mk(Y, N, N, N, N, N, 2'b10, Y, N, 2'b00, 2'b10, 2'b00, N);
    localparam ctl_t C_TRAP    = mk(N, N, N, N, N, N, 2'b00, N, N, 2'b00, 2'b00, 2'b00, Y);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset16 = 1'b1;
    logic reset4 = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    ctl_t obs16;
    ctl_t obs4;

    multicycle_control_if bus16 ();
    multicycle_control_if bus4 ();

    multicycle_control #(.MEM_TIMEOUT(16)) dut16 (.clk(clk), .reset(reset16), .bus(bus16));
    multicycle_control #(.MEM_TIMEOUT(4))  dut4  (.clk(clk), .reset(reset4),  .bus(bus4));

    always #5 clk = ~clk;

    always_comb obs16 = {bus16.pcwrite, bus16.pcwritecond, bus16.iord, bus16.memread,
                         bus16.memwrite, bus16.irwrite, bus16.memtoreg, bus16.regwrite,
                         bus16.alusrca, bus16.alusrcb, bus16.pcsource, bus16.aluop, bus16.trap};
    always_comb obs4  = {bus4.pcwrite, bus4.pcwritecond, bus4.iord, bus4.memread,
                         bus4.memwrite, bus4.irwrite, bus4.memtoreg, bus4.regwrite,
                         bus4.alusrca, bus4.alusrcb, bus4.pcsource, bus4.aluop, bus4.trap};

    function automatic void check(input string nm, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, (e.dut == 0) ? obs16 : obs4, e.exp);
            end
        end
    end

    task automatic cyc(input int unsigned d, input logic [6:0] op, input logic mr,
                       input ctl_t e, input string nm);
        exp_t x;
        if (d == 0) begin
            bus16.opcode    = op;
            bus16.mem_ready = mr;
        end else begin
            bus4.opcode    = op;
            bus4.mem_ready = mr;
        end
        x.dut  = d;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        exp_t x;
        bus16.opcode = '0;
        bus16.mem_ready = 1'b0;
        bus4.opcode = '0;
        bus4.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) cyc(0, OP_R, Y, C_ZERO, "reset_hold");
        reset16 = 1'b0;
        cyc(0, OP_R, Y, C_ZERO,    "r_idle");
        cyc(0, OP_R, Y, C_FETCH_R, "r_fetch");
        cyc(0, OP_R, Y, C_DECODE,  "r_decode");
        cyc(0, OP_R, Y, C_EXEC_R,  "r_exec");
        cyc(0, OP_R, Y, C_ALU_WB,  "r_wb");

        cyc(0, OP_LD,  Y, C_FETCH_R, "ld_fetch");
        cyc(0, OP_LD,  Y, C_DECODE,  "ld_decode");
        cyc(0, OP_BAD, N, C_ADDR,    "ld_addr");
        for (int i = 0; i < 5; i++) cyc(0, OP_BAD, N, C_MEM_RD, "ld_stall");
        cyc(0, OP_BAD, Y, C_MEM_RD,  "ld_done");
        cyc(0, OP_BAD, N, C_LOAD_WB, "ld_wb");

        cyc(0, OP_I, Y, C_FETCH_R, "i_fetch");
        cyc(0, OP_I, N, C_DECODE,  "i_decode");
        cyc(0, OP_I, N, C_EXEC_I,  "i_exec");
        cyc(0, OP_I, N, C_ALU_WB,  "i_wb");

        cyc(0, OP_BR, Y, C_FETCH_R, "br_fetch");
        cyc(0, OP_BR, Y, C_DECODE,  "br_decode");
        cyc(0, OP_BR, Y, C_BRANCH,  "br_exec");

        cyc(0, OP_JAL, Y, C_FETCH_R, "jal_fetch");
        cyc(0, OP_JAL, Y, C_DECODE,  "jal_decode");
        cyc(0, OP_JAL, Y, C_JAL,     "jal_exec");

        cyc(0, OP_ST, N, C_FETCH_S, "st_fetch_stall");
        cyc(0, OP_ST, Y, C_FETCH_R, "st_fetch");
        cyc(0, OP_ST, Y, C_DECODE,  "st_decode");
        cyc(0, OP_LD, Y, C_ADDR,    "st_addr");
        cyc(0, OP_LD, Y, C_MEM_WR,  "st_write");

        // Store stalled in MEM_WR, then reset asserted between clock edges.
        cyc(0, OP_ST, Y, C_FETCH_R, "ab_fetch");
        cyc(0, OP_ST, Y, C_DECODE,  "ab_decode");
        cyc(0, OP_ST, N, C_ADDR,    "ab_addr");
        cyc(0, OP_ST, N, C_MEM_WR,  "ab_stall");
        x.dut = 0;
        x.exp = C_MEM_WR;
        x.name = "ab_stall_pre";
        sb.push_back(x);
        @(negedge clk);
        #1;
        reset16 = 1'b1;
        #1;
        check("ab_async_drop", obs16, C_ZERO);
        @(posedge clk);
        #1;
        cyc(0, OP_ST, N, C_ZERO, "ab_reset");
        reset16 = 1'b0;
        cyc(0, OP_ST, N, C_ZERO,    "ab_idle");
        cyc(0, OP_R,  Y, C_FETCH_R, "ab_refetch");

        cyc(0, OP_BAD, Y, C_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++) cyc(0, 7'(i), logic'(i % 2), C_TRAP, "ill_trap");
        reset16 = 1'b1;
        cyc(0, OP_R, Y, C_ZERO, "ill_reset");
        reset16 = 1'b0;
        cyc(0, OP_R, Y, C_ZERO,    "ill_idle");
        cyc(0, OP_R, N, C_FETCH_S, "ill_fetch");

        reset4 = 1'b0;
        cyc(1, OP_R, N, C_ZERO, "t4_idle");
        for (int i = 0; i < 4; i++) cyc(1, OP_R, N, C_FETCH_S, "t4_fetch_stall");
        cyc(1, OP_R, Y, C_TRAP, "t4_trap");
        cyc(1, OP_R, Y, C_TRAP, "t4_trap_hold");
        reset4 = 1'b1;
        cyc(1, OP_R, N, C_ZERO, "t4_reset");
        reset4 = 1'b0;
        cyc(1, OP_R, N, C_ZERO, "t4_idle2");
        for (int i = 0; i < 3; i++) cyc(1, OP_R, N, C_FETCH_S, "t4_stall3");
        cyc(1, OP_R, Y, C_FETCH_R, "t4_ready_last");
        cyc(1, OP_R, N, C_DECODE,  "t4_decode");
        cyc(1, OP_R, N, C_EXEC_R,  "t4_exec");
        cyc(1, OP_R, N, C_ALU_WB,  "t4_wb");
        cyc(1, OP_ST, Y, C_FETCH_R, "t4_st_fetch");
        cyc(1, OP_ST, N, C_DECODE,  "t4_st_decode");
        cyc(1, OP_ST, N, C_ADDR,    "t4_st_addr");
        for (int i = 0; i < 4; i++) cyc(1, OP_ST, N, C_MEM_WR, "t4_wr_stall");
        cyc(1, OP_ST, Y, C_TRAP, "t4_wr_trap");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
